// File: rtl/mult_div_if.sv
// mult_div_if: start/operand/result bundle between the control unit and mult_div_ctrl.
// The uns select exists only when MULT_DIV_UNSIGNED_EN is defined.
interface mult_div_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
`ifdef MULT_DIV_UNSIGNED_EN
    logic             uns;
`endif
    logic             busy;
    logic             done;
    logic             div0;
    logic             hi_write;
    logic             lo_write;
    logic [WIDTH-1:0] hi_data;
    logic [WIDTH-1:0] lo_data;

    modport master (
        output start, op, src_a, src_b,
`ifdef MULT_DIV_UNSIGNED_EN
        output uns,
`endif
        input  busy, done, div0, hi_write, lo_write, hi_data, lo_data
    );

    modport slave (
        input  start, op, src_a, src_b,
`ifdef MULT_DIV_UNSIGNED_EN
        input  uns,
`endif
        output busy, done, div0, hi_write, lo_write, hi_data, lo_data
    );
endinterface

// File: rtl/mult_div_ctrl.sv
// mult_div_ctrl: multicycle sequencer for the shared multiply/divide unit.
// Radix-2 Booth multiply and restoring divide, one bit per cycle, results to HI/LO.
// MULT_DIV_UNSIGNED_EN adds the uns select for multu/divu.
module mult_div_ctrl #(
    parameter int WIDTH = 32
) (
    input logic       clock,
    input logic       reset,
    mult_div_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, MULT, DIV, FIX, WB} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   acc;
    logic [WIDTH:0]   mcand;
    logic [WIDTH-1:0] q;
    logic             qm1;
    logic             mfix;
    logic             neg_q;
    logic             neg_r;
    logic             busy_r;
    logic             done_r;
    logic             div0_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;

    logic             uns;
    logic             sa;
    logic             sb;
    logic             last;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   bsum;
    logic [WIDTH:0]   bacc_n;
    logic [WIDTH-1:0] bq_n;
    logic [WIDTH:0]   rsh;
    logic             ge;
    logic [WIDTH:0]   dacc_n;
    logic [WIDTH-1:0] dq_n;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;

`ifdef MULT_DIV_UNSIGNED_EN
    assign uns = bus.uns;
`else
    assign uns = 1'b0;
`endif

    // Operand signs are only meaningful for signed operations.
    assign sa    = bus.src_a[WIDTH-1] & ~uns;
    assign sb    = bus.src_b[WIDTH-1] & ~uns;
    assign mag_a = sa ? -bus.src_a : bus.src_a;
    assign mag_b = sb ? -bus.src_b : bus.src_b;
    assign last  = (cnt == CW'(WIDTH - 1));

    // One Booth step: add/subtract the multiplicand per {Q[0], q-1}, then arithmetic shift right.
    always_comb begin
        bsum   = (q[0] == qm1) ? acc : (q[0] ? acc - mcand : acc + mcand);
        bacc_n = {bsum[WIDTH], bsum[WIDTH:1]};
        bq_n   = {bsum[0], q[WIDTH-1:1]};
    end

    // One restoring-divide step on magnitudes: shift {R, Q} left, keep the difference if it fits.
    always_comb begin
        rsh    = {acc[WIDTH-1:0], q[WIDTH-1]};
        ge     = (rsh >= mcand);
        dacc_n = ge ? rsh - mcand : rsh;
        dq_n   = {q[WIDTH-2:0], ge};
    end

    // Sign fix-up of the magnitude results: quotient truncates toward zero, remainder follows the dividend.
    always_comb begin
        quo = neg_q ? -q : q;
        rem = neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    end

    // Sequencer: latches operands on start, iterates, and registers every output.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            q      <= '0;
            qm1    <= 1'b0;
            mfix   <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            div0_r <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
        end else begin
            done_r <= 1'b0;
            div0_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        cnt   <= '0;
                        acc   <= '0;
                        qm1   <= 1'b0;
                        mfix  <= uns & bus.src_b[WIDTH-1];
                        neg_q <= sa ^ sb;
                        neg_r <= sa;
                        if (!bus.op) begin
                            mcand  <= {sa, bus.src_a};
                            q      <= bus.src_b;
                            busy_r <= 1'b1;
                            state  <= MULT;
                        end else if (bus.src_b == '0) begin
                            div0_r <= 1'b1;
                        end else begin
                            mcand  <= {1'b0, mag_b};
                            q      <= mag_a;
                            busy_r <= 1'b1;
                            state  <= DIV;
                        end
                    end
                end
                MULT: begin
                    acc <= bacc_n;
                    q   <= bq_n;
                    qm1 <= q[0];
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        // Booth reads the multiplier as signed; an unsigned multiplier with its MSB set needs +A in HI.
                        hi_r   <= bacc_n[WIDTH-1:0] + (mfix ? mcand[WIDTH-1:0] : '0);
                        lo_r   <= bq_n;
                        done_r <= 1'b1;
                        state  <= WB;
                    end
                end
                DIV: begin
                    acc <= dacc_n;
                    q   <= dq_n;
                    cnt <= cnt + 1'b1;
                    if (last) state <= FIX;
                end
                FIX: begin
                    hi_r   <= rem;
                    lo_r   <= quo;
                    done_r <= 1'b1;
                    state  <= WB;
                end
                WB: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.div0     = div0_r;
    assign bus.hi_write = done_r;
    assign bus.lo_write = done_r;
    assign bus.hi_data  = hi_r;
    assign bus.lo_data  = lo_r;
endmodule

// File: tb/tb_mult_div_ctrl.sv
// tb_mult_div_ctrl: randomized self-checking bench for mult_div_ctrl against an arithmetic reference model.
module tb_mult_div_ctrl;
    logic clock = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    mult_div_if #(.WIDTH(32)) bus ();

    mult_div_ctrl #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on sign- or zero-extended operands; returns {hi, lo}.
    function automatic logic [63:0] model(input logic o, input logic [31:0] a, input logic [31:0] b, input logic u);
        longint x, y, p, qq, rr;
        logic [63:0] r;
        x = u ? longint'(a) : longint'($signed(a));
        y = u ? longint'(b) : longint'($signed(b));
        if (!o) begin
            p = x * y;
            r = p;
        end else begin
            qq = x / y;
            rr = x % y;
            r = {rr[31:0], qq[31:0]};
        end
        return r;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Issues one operation at the next edge and observes 40 cycles; inj>0 pulses a stray start in that cycle.
    task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b, input logic u, input int inj);
        logic [63:0] m;
        logic [63:0] got_hi;
        logic [63:0] got_lo;
        int lat, done_at, done_n, div0_at, div0_n, busy_err, wr_err;
        logic z;
        z = o && (b == 32'h0);
        lat = z ? 0 : (o ? 34 : 33);
        if (z) inj = 0;
        got_hi = 'x;
        got_lo = 'x;
        done_at = 0; done_n = 0; div0_at = 0; div0_n = 0; busy_err = 0; wr_err = 0;
        bus.start = 1'b1;
        bus.op = o;
        bus.src_a = a;
        bus.src_b = b;
`ifdef MULT_DIV_UNSIGNED_EN
        bus.uns = u;
`endif
        if (!z) begin
            m = model(o, a, b, u);
            exp_hi = m[63:32];
            exp_lo = m[31:0];
        end
        @(posedge clock); #1;
        bus.start = 1'b0;
        bus.op = 1'($urandom);
        bus.src_a = $urandom;
        bus.src_b = $urandom;
`ifdef MULT_DIV_UNSIGNED_EN
        bus.uns = 1'($urandom);
`endif
        for (int k = 1; k <= 40; k++) begin
            if (bus.busy !== (k <= lat)) busy_err++;
            if (bus.hi_write !== bus.done || bus.lo_write !== bus.done) wr_err++;
            if (bus.done === 1'b1) begin
                done_n++;
                done_at = k;
                got_hi = bus.hi_data;
                got_lo = bus.lo_data;
            end
            if (bus.div0 === 1'b1) begin
                div0_n++;
                div0_at = k;
            end
            if (k == inj) begin
                bus.start = 1'b1;
                bus.op = 1'($urandom);
                bus.src_a = $urandom;
                bus.src_b = $urandom;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clock); #1;
        end
        bus.start = 1'b0;
        check("busy_pattern", busy_err, 0);
        check("write_enables", wr_err, 0);
        if (z) begin
            check("div0_count", div0_n, 1);
            check("div0_cycle", div0_at, 1);
            check("div0_no_done", done_n, 0);
        end else begin
            check("div0_absent", div0_n, 0);
            check("done_count", done_n, 1);
            check("done_cycle", done_at, lat);
            check("hi_data", got_hi, {32'h0, exp_hi});
            check("lo_data", got_lo, {32'h0, exp_lo});
        end
        check("hi_hold", bus.hi_data, exp_hi);
        check("lo_hold", bus.lo_data, exp_lo);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr_seen;
        logic o, u;
        logic [31:0] a, b;
        int inj;
        reset = 1'b0;
        bus.start = 1'b0;
        bus.op = 1'b0;
        bus.src_a = '0;
        bus.src_b = '0;
`ifdef MULT_DIV_UNSIGNED_EN
        bus.uns = 1'b0;
`endif
        exp_hi = '0;
        exp_lo = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_div0", bus.div0, 0);
        check("rst_writes", {bus.hi_write, bus.lo_write}, 0);
        check("rst_hi", bus.hi_data, 0);
        check("rst_lo", bus.lo_data, 0);
        reset = 1'b1;
        @(posedge clock); #1;

        run_op(1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0, 0);
        run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 0);
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0, 0);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
        run_op(1'b1, 32'd5, 32'd0, 1'b0, 0);
        run_op(1'b0, 32'd2, 32'd3, 1'b0, 0);
        run_op(1'b1, 32'd1000, 32'hFFFF_FFF9, 1'b0, 10);
`ifdef MULT_DIV_UNSIGNED_EN
        run_op(1'b1, 32'hFFFF_FFFF, 32'd2, 1'b1, 0);
        run_op(1'b0, 32'hFFFF_FFFF, 32'd2, 1'b1, 0);
        run_op(1'b0, 32'h8000_0001, 32'hF000_0003, 1'b1, 0);
`endif

        // Reset in the middle of a multiply: everything clears and nothing is written.
        bus.start = 1'b1;
        bus.op = 1'b0;
        bus.src_a = 32'd9;
        bus.src_b = 32'd11;
        @(posedge clock); #1;
        bus.start = 1'b0;
        repeat (11) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        exp_hi = '0;
        exp_lo = '0;
        check("abort_busy", bus.busy, 0);
        check("abort_hi", bus.hi_data, 0);
        check("abort_lo", bus.lo_data, 0);
        wr_seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clock); #1;
            if (bus.done !== 1'b0 || bus.hi_write !== 1'b0 || bus.lo_write !== 1'b0) wr_seen++;
        end
        check("abort_no_write", wr_seen, 0);
        reset = 1'b1;
        @(posedge clock); #1;
        run_op(1'b0, 32'd2, 32'd3, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            o = 1'($urandom);
            a = pick();
            b = pick();
`ifdef MULT_DIV_UNSIGNED_EN
            u = 1'($urandom);
`else
            u = 1'b0;
`endif
            inj = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(2, o ? 34 : 33));
            run_op(o, a, b, u, inj);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
